// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory access controller
// No ports; provides the FSM state enum, halt opcode and opcode field bounds.
package mem_ctrl_pkg;
  localparam int ADDR_W_DFLT = 8;
  localparam int DATA_W_DFLT = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam logic [OPC_MSB-OPC_LSB:0] HALT_OP = 6'b001111;
  typedef enum logic [1:0] {S_IDLE, S_FRD, S_DRD} state_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port RAM initiator for instruction fetch and CPU loads/stores
// Ports: clk/clr (async active-high reset); mem_* drive the RAM, mem_rdata is its
// registered read data; if_* is the one-entry instruction buffer toward decode;
// br_* redirects fetch; dreq_*/dresp_* carry CPU data accesses; halted flags HALT_OP.
module mem_access_ctrl #(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DFLT,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W_DFLT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OP = mem_ctrl_pkg::HALT_OP
) (
  input  logic              clk,
  input  logic              clr,
  output logic              mem_ce,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              dreq_valid,
  output logic              dreq_ready,
  input  logic              dreq_we,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              dresp_valid,
  output logic [DATA_W-1:0] dresp_rdata,
  output logic              halted
);
  import mem_ctrl_pkg::*;
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, r_if_pc;
  logic [DATA_W-1:0] r_if_instr, r_dresp_rdata;
  logic r_if_valid, r_halted, r_dresp_valid;
  logic w_idle_free;
  // Port is free to issue only in S_IDLE without a redirect; clr masks issue so
  // mem_ce drops the moment reset asserts, before any clock edge.
  assign w_idle_free = !clr && r_state == S_IDLE && !br_valid;
  always_comb begin
    w_state_nx = S_IDLE;
    dreq_ready = 1'b0;
    mem_ce = 1'b0;
    mem_rw = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    if (w_idle_free && dreq_valid) begin
      dreq_ready = 1'b1;
      mem_ce = 1'b1;
      mem_rw = !dreq_we;
      mem_addr = dreq_addr;
      mem_wdata = dreq_we ? dreq_wdata : '0;
      w_state_nx = dreq_we ? S_IDLE : S_DRD;
    end else if (w_idle_free && !r_halted && (!r_if_valid || if_ready)) begin
      mem_ce = 1'b1;
      mem_rw = 1'b1;
      mem_addr = r_pc;
      w_state_nx = S_FRD;
    end
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  // A redirect in any state flushes the buffer; a pending load still completes.
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_pc <= RESET_PC;
      r_if_pc <= '0;
      r_if_instr <= '0;
      r_if_valid <= 1'b0;
      r_halted <= 1'b0;
      r_dresp_valid <= 1'b0;
      r_dresp_rdata <= '0;
    end else begin
      r_dresp_valid <= r_state == S_DRD;
      if (r_state == S_DRD) r_dresp_rdata <= mem_rdata;
      if (br_valid) begin
        r_pc <= br_target;
        r_if_valid <= 1'b0;
        r_halted <= 1'b0;
      end else if (r_state == S_FRD) begin
        r_if_instr <= mem_rdata;
        r_if_pc <= r_pc;
        r_if_valid <= 1'b1;
        r_pc <= r_pc + ADDR_W'(1);
        r_halted <= mem_rdata[OPC_MSB:OPC_LSB] == HALT_OP;
      end else if (r_if_valid && if_ready) r_if_valid <= 1'b0;
    end
  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc = r_if_pc;
  assign halted = r_halted;
  assign dresp_valid = r_dresp_valid;
  assign dresp_rdata = r_dresp_rdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of fetch, backpressure, loads/stores, redirects and reset
module tb_mem_access_ctrl;
  localparam logic [15:0] IMG [11] = '{16'h3803, 16'h0005, 16'h0404, 16'h0801, 16'h0C02,
    16'h1404, 16'h1802, 16'h2003, 16'h1C02, 16'h0402, 16'h3C00};
  logic clk, clr;
  logic mem_ce, mem_rw;
  logic [7:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic if_valid, if_ready;
  logic [15:0] if_instr;
  logic [7:0] if_pc;
  logic br_valid;
  logic [7:0] br_target;
  logic dreq_valid, dreq_ready, dreq_we;
  logic [7:0] dreq_addr;
  logic [15:0] dreq_wdata;
  logic dresp_valid;
  logic [15:0] dresp_rdata;
  logic halted;
  int checks = 0;
  int errors = 0;
  mem_access_ctrl dut (
    .clk(clk), .clr(clr), .mem_ce(mem_ce), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .br_valid(br_valid), .br_target(br_target),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .halted(halted)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] mem [256];
  logic [15:0] mem_q;
  logic mem_pend = 1'b0;
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int a = 0; a < 256; a++) mem[a] <= (a < 11) ? IMG[a] : 16'h0000;
      seeded <= 1'b1;
    end else if (mem_ce && !mem_rw) mem[mem_addr] <= mem_wdata;
    mem_pend <= mem_ce && mem_rw;
    if (mem_ce && mem_rw) mem_q <= mem[mem_addr];
  end
  assign mem_rdata = mem_pend ? mem_q : 16'hzzzz;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    clr = 1'b1; if_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    dreq_valid = 1'b0; dreq_we = 1'b0; dreq_addr = '0; dreq_wdata = '0;
    repeat (3) step();
    dreq_valid = 1'b1; dreq_addr = 8'h10; #1;
    chk("rst_ce", mem_ce, 0); chk("rst_ready", dreq_ready, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_ivalid", if_valid, 0); chk("rst_instr", if_instr, 0); chk("rst_pc", if_pc, 0);
    chk("rst_halted", halted, 0); chk("rst_dresp", dresp_valid, 0); chk("rst_drdata", dresp_rdata, 0);
    dreq_valid = 1'b0;
    step(); clr = 1'b0; #1;
    chk("f0_ce", mem_ce, 1); chk("f0_rw", mem_rw, 1); chk("f0_addr", mem_addr, 0);
    step();
    chk("f0_frd_ce", mem_ce, 0); chk("f0_frd_valid", if_valid, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", if_valid, 1); chk("bp_instr", if_instr, 16'h3803);
      chk("bp_pc", if_pc, 0); chk("bp_ce", mem_ce, 0);
      step();
    end
    if_ready = 1'b1; #1;
    chk("rel_ce", mem_ce, 1); chk("rel_addr", mem_addr, 1);
    step(); step();
    for (int i = 1; i <= 10; i++) begin
      chk("seq_valid", if_valid, 1); chk("seq_instr", if_instr, IMG[i]); chk("seq_pc", if_pc, i);
      if (i < 10) begin
        chk("seq_ce", mem_ce, 1); chk("seq_addr", mem_addr, i + 1);
        step(); chk("seq_gap", if_valid, 0); step();
      end
    end
    chk("halt_set", halted, 1); chk("halt_ce0", mem_ce, 0);
    repeat (3) begin step(); chk("halt_ce", mem_ce, 0); end
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 8'hFF; dreq_wdata = 16'hBEEF; #1;
    chk("st_ready", dreq_ready, 1); chk("st_ce", mem_ce, 1); chk("st_rw", mem_rw, 0);
    chk("st_addr", mem_addr, 8'hFF); chk("st_wdata", mem_wdata, 16'hBEEF);
    step(); dreq_we = 1'b0; #1;
    chk("ld_ready", dreq_ready, 1); chk("ld_ce", mem_ce, 1); chk("ld_rw", mem_rw, 1);
    step();
    chk("drd_ready", dreq_ready, 0); chk("drd_ce", mem_ce, 0); chk("drd_dresp", dresp_valid, 0);
    dreq_valid = 1'b0;
    step();
    chk("ld_dresp", dresp_valid, 1); chk("ld_rdata", dresp_rdata, 16'hBEEF);
    step(); chk("ld_pulse_end", dresp_valid, 0);
    br_valid = 1'b1; br_target = 8'h03; #1;
    chk("br_halt_ce", mem_ce, 0);
    step(); br_valid = 1'b0; #1;
    chk("br_unhalt", halted, 0); chk("br_f_ce", mem_ce, 1); chk("br_f_addr", mem_addr, 3);
    step();
    br_valid = 1'b1; br_target = 8'h08;
    step(); br_valid = 1'b0; #1;
    chk("sq_valid", if_valid, 0); chk("sq_ce", mem_ce, 1); chk("sq_addr", mem_addr, 8);
    step(); step();
    chk("sq_instr", if_instr, 16'h1C02); chk("sq_pc", if_pc, 8);
    br_valid = 1'b1; br_target = 8'hFF; #1;
    chk("brff_ce", mem_ce, 0);
    step(); br_valid = 1'b0; #1;
    chk("brff_flush", if_valid, 0); chk("brff_addr", mem_addr, 8'hFF);
    step(); step();
    chk("ff_pc", if_pc, 8'hFF); chk("ff_instr", if_instr, 16'hBEEF); chk("wrap_addr", mem_addr, 0);
    step(); step();
    chk("wrap_pc", if_pc, 0); chk("wrap_instr", if_instr, 16'h3803);
    step();
    dreq_valid = 1'b1; dreq_we = 1'b0; dreq_addr = 8'h05; #1;
    chk("lf_frd_ready", dreq_ready, 0); chk("lf_frd_ce", mem_ce, 0);
    step();
    chk("lf_ready", dreq_ready, 1); chk("lf_addr", mem_addr, 5); chk("lf_rw", mem_rw, 1);
    step(); dreq_valid = 1'b0; #1;
    chk("lf_drd_dresp", dresp_valid, 0); chk("lf_drd_ce", mem_ce, 0);
    step();
    chk("lf_dresp", dresp_valid, 1); chk("lf_rdata", dresp_rdata, 16'h1404);
    chk("lf_resume_ce", mem_ce, 1); chk("lf_resume_addr", mem_addr, 2);
    step(); step();
    if_ready = 1'b0; dreq_valid = 1'b1; dreq_addr = 8'h00; #1;
    chk("r6_ld_ready", dreq_ready, 1);
    step(); dreq_valid = 1'b0; #1;
    chk("r6_pre_valid", if_valid, 1);
    clr = 1'b1; #1;
    chk("r6d_ce", mem_ce, 0); chk("r6d_valid", if_valid, 0); chk("r6d_instr", if_instr, 0);
    chk("r6d_pc", if_pc, 0); chk("r6d_drdata", dresp_rdata, 0); chk("r6d_halted", halted, 0);
    step(); clr = 1'b0; if_ready = 1'b1; #1;
    chk("r6d_f_ce", mem_ce, 1); chk("r6d_f_addr", mem_addr, 0);
    step(); step();
    chk("r6d_instr0", if_instr, 16'h3803);
    step();
    clr = 1'b1; dreq_valid = 1'b1; #1;
    chk("r6f_ce", mem_ce, 0); chk("r6f_ready", dreq_ready, 0); chk("r6f_valid", if_valid, 0);
    chk("r6f_dresp", dresp_valid, 0);
    dreq_valid = 1'b0;
    step(); clr = 1'b0; #1;
    chk("r6f_f_ce", mem_ce, 1); chk("r6f_f_addr", mem_addr, 0);
    step(); step();
    chk("r6f_instr", if_instr, 16'h3803); chk("r6f_pc", if_pc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
